// File: rtl/mem_vpaddr_arbiter.sv
// mem_vpaddr_arbiter: one-outstanding arbiter between fetch and LSU onto a single memory port,
// with fixed MIPS32 kseg0/kseg1 translation. Define MEM_VPADDR_ARB_ROUND_ROBIN_EN for round-robin grant.
module mem_vpaddr_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  input  logic [31:0]         i_req_vaddr,
  output logic                i_req_ready,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  input  logic [31:0]         d_req_vaddr,
  input  logic                d_req_wen,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_req_ready,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                m_req_valid,
  output logic [31:0]         m_req_paddr,
  output logic                m_req_wen,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  output logic                m_req_uncached,
  input  logic                m_req_ready,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_resp_data,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  state_t      state, state_next;
  owner_t      owner;
  logic        grant_i, grant_d;
  logic        accept;
  logic [31:0] sel_vaddr;

  // kseg0 (100) and kseg1 (101) both alias the low 512 MiB of physical space.
  function automatic logic [31:0] phys_addr(input logic [31:0] vaddr);
    if (vaddr[31:30] == 2'b10) return {3'b000, vaddr[28:0]};
    return vaddr;
  endfunction

`ifdef MEM_VPADDR_ARB_ROUND_ROBIN_EN
  owner_t last_grant;

  // Reset to "data last" so fetch wins the first contended grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= OWNER_D;
    else if (accept) last_grant <= grant_d ? OWNER_D : OWNER_I;
  end

  always_comb begin
    grant_i = i_req_valid;
    grant_d = d_req_valid;
    if (i_req_valid && d_req_valid) begin
      grant_i = (last_grant == OWNER_D);
      grant_d = (last_grant == OWNER_I);
    end
  end
`else
  assign grant_d = d_req_valid;
  assign grant_i = i_req_valid & ~d_req_valid;
`endif

  assign sel_vaddr = grant_d ? d_req_vaddr : i_req_vaddr;
  assign accept    = i_req_ready | d_req_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    case (state)
      IDLE: begin
        // Readies are held low while reset is asserted, even though the FSM already reads IDLE.
        i_req_ready = grant_i & ~reset;
        d_req_ready = grant_d & ~reset;
        if (grant_i || grant_d) state_next = ISSUE;
      end
      ISSUE: begin
        if (m_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (m_resp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured and translated once, at accept, and held through ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner          <= OWNER_I;
      m_req_paddr    <= '0;
      m_req_uncached <= 1'b0;
      m_req_wen      <= 1'b0;
      m_req_wdata    <= '0;
      m_req_wstrb    <= '0;
    end else if (accept) begin
      owner          <= grant_d ? OWNER_D : OWNER_I;
      m_req_paddr    <= phys_addr(sel_vaddr);
      m_req_uncached <= (sel_vaddr[31:29] == 3'b101);
      m_req_wen      <= grant_d & d_req_wen;
      m_req_wdata    <= grant_d ? d_req_wdata : '0;
      m_req_wstrb    <= grant_d ? d_req_wstrb : '0;
    end
  end

  // Responses are registered: the owner sees a one-cycle pulse the cycle after m_resp_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      i_resp_data  <= '0;
      d_resp_data  <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      if (state == WAIT && m_resp_valid) begin
        if (owner == OWNER_D) begin
          d_resp_valid <= 1'b1;
          d_resp_data  <= m_resp_data;
        end else begin
          i_resp_valid <= 1'b1;
          i_resp_data  <= m_resp_data;
        end
      end
    end
  end

  assign m_req_valid = (state == ISSUE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_vpaddr_arbiter.sv
// Self-checking bench for mem_vpaddr_arbiter: directed scenarios plus randomized single-requester
// traffic checked against a segment-range address model and a grant-order model.
`timescale 1ns/1ps
module tb_mem_vpaddr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_req_vaddr, i_resp_data;
  logic        d_req_valid, d_req_wen, d_req_ready, d_resp_valid;
  logic [31:0] d_req_vaddr, d_req_wdata, d_resp_data;
  logic [3:0]  d_req_wstrb;
  logic        m_req_valid, m_req_wen, m_req_uncached, m_req_ready, m_resp_valid;
  logic [31:0] m_req_paddr, m_req_wdata, m_resp_data;
  logic [3:0]  m_req_wstrb;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_vpaddr_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_vaddr(i_req_vaddr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_vaddr(d_req_vaddr), .d_req_wen(d_req_wen),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_paddr(m_req_paddr), .m_req_wen(m_req_wen),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb), .m_req_uncached(m_req_uncached),
    .m_req_ready(m_req_ready), .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observation of one transaction; req = {m_req_valid, paddr, uncached, wen, wdata, wstrb}.
  typedef struct {
    logic        timed_out;
    logic [70:0] req;
    int          stall_bad;
    int          stray_resp;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic [1:0]  after;
  } obs_t;

  // Address model written as segment ranges rather than bit fields.
  function automatic logic [31:0] ref_paddr(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
    if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
    return va;
  endfunction

  function automatic logic ref_uncached(input logic [31:0] va);
    return (va >= 32'hA000_0000 && va < 32'hC000_0000);
  endfunction

  function automatic logic [70:0] ref_req(input logic is_d, input logic [31:0] va, input logic wen,
                                          input logic [31:0] wd, input logic [3:0] ws);
    if (is_d) return {1'b1, ref_paddr(va), ref_uncached(va), wen, wd, ws};
    return {1'b1, ref_paddr(va), ref_uncached(va), 1'b0, 32'h0, 4'h0};
  endfunction

  task automatic idle_inputs();
    i_req_valid = 0; i_req_vaddr = '0;
    d_req_valid = 0; d_req_vaddr = '0; d_req_wen = 0; d_req_wdata = '0; d_req_wstrb = '0;
    m_req_ready = 0; m_resp_valid = 0; m_resp_data = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  // Drives one request from a single requester and plays the downstream side; returns observations.
  task automatic run_txn(input logic is_d, input logic [31:0] va, input logic wen,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd,
                         input int stall, input int lat, input logic stray, output obs_t o);
    logic [70:0] snap;
    int n;
    o.timed_out = 0; o.req = '0; o.stall_bad = 0; o.stray_resp = 0;
    o.rv = '0; o.rd = '0; o.after = '0;
    @(negedge clk);
    if (is_d) begin
      d_req_valid = 1; d_req_vaddr = va; d_req_wen = wen; d_req_wdata = wd; d_req_wstrb = ws;
    end else begin
      i_req_valid = 1; i_req_vaddr = va;
      // Idle data-side fields carry junk that must not leak into a fetch.
      d_req_wen = 1; d_req_wdata = $urandom | 32'h1; d_req_wstrb = 4'hF;
    end
    #1;
    n = 0;
    while (!(is_d ? d_req_ready : i_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      o.timed_out = 1;
      idle_inputs();
      return;
    end
    @(negedge clk);
    i_req_valid = 0; d_req_valid = 0;
    // A competing requester stays valid during a stall and must not be granted.
    if (stall > 0) begin
      if (is_d) begin i_req_valid = 1; i_req_vaddr = 32'h0040_0000; end
      else      begin d_req_valid = 1; d_req_vaddr = 32'h0040_0000; d_req_wen = 0; end
    end
    m_req_ready = (stall == 0);
    #1;
    o.req = {m_req_valid, m_req_paddr, m_req_uncached, m_req_wen, m_req_wdata, m_req_wstrb};
    snap  = o.req;
    for (int k = 0; k < stall; k++) begin
      if ({m_req_valid, m_req_paddr, m_req_uncached, m_req_wen, m_req_wdata, m_req_wstrb} !== snap ||
          busy !== 1'b1 || i_req_ready !== 1'b0 || d_req_ready !== 1'b0)
        o.stall_bad++;
      m_resp_valid = stray && (k == 0);
      m_resp_data  = 32'hBAD0_0BAD;
      @(negedge clk);
      m_resp_valid = 0;
      if (k == stall - 1) begin
        m_req_ready = 1; i_req_valid = 0; d_req_valid = 0;
      end
      #1;
      if (i_resp_valid || d_resp_valid) o.stray_resp++;
    end
    @(negedge clk);
    m_req_ready = 0;
    repeat (lat) @(negedge clk);
    m_resp_valid = 1; m_resp_data = rd;
    @(negedge clk);
    m_resp_valid = 0; m_resp_data = $urandom;
    #1;
    o.rv = {i_resp_valid, d_resp_valid};
    o.rd = is_d ? d_resp_data : i_resp_data;
    o.after[1] = busy;
    @(negedge clk); #1;
    o.after[0] = i_resp_valid | d_resp_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    i_req_valid = 1; d_req_valid = 1; i_req_vaddr = 32'hBFC0_0000; d_req_vaddr = 32'h8000_0000;
    #1;
    total_cnt++;
    if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, busy, m_req_valid} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, busy, m_req_valid});
    else pass_cnt++;
    total_cnt++;
    if ({m_req_paddr, m_req_wen, m_req_wdata, m_req_wstrb, m_req_uncached, i_resp_data, d_resp_data} !== '0)
      $display("FAIL reset_data: paddr=%h wdata=%h idata=%h ddata=%h expected all zero", m_req_paddr, m_req_wdata, i_resp_data, d_resp_data);
    else pass_cnt++;
    @(negedge clk);
    idle_inputs();
    reset = 0;
    #1;
    total_cnt++;
    if ({busy, i_req_ready, d_req_ready} !== 3'b0)
      $display("FAIL reset_release_idle: got %b expected 000", {busy, i_req_ready, d_req_ready});
    else pass_cnt++;
  endtask

  task automatic test_fetch_kseg1();
    obs_t o;
    run_txn(1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2, 1'b0, o);
    total_cnt++;
    if (o.timed_out !== 1'b0) $display("FAIL fetch_accept: timed out waiting for i_req_ready");
    else pass_cnt++;
    total_cnt++;
    if (o.req !== {1'b1, 32'h1FC0_0000, 1'b1, 1'b0, 32'h0, 4'h0})
      $display("FAIL fetch_req: got %h expected %h", o.req, {1'b1, 32'h1FC0_0000, 1'b1, 1'b0, 32'h0, 4'h0});
    else pass_cnt++;
    total_cnt++;
    if (o.rv !== 2'b10) $display("FAIL fetch_resp_route: got {i,d}=%b expected 10", o.rv);
    else pass_cnt++;
    total_cnt++;
    if (o.rd !== 32'hDEAD_BEEF) $display("FAIL fetch_resp_data: got %h expected deadbeef", o.rd);
    else pass_cnt++;
    total_cnt++;
    if (o.after !== 2'b00) $display("FAIL fetch_after: got {busy,pulse_next}=%b expected 00", o.after);
    else pass_cnt++;
  endtask

  task automatic test_data_write();
    obs_t o;
    run_txn(1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0011, 32'h0, 0, 1, 1'b0, o);
    total_cnt++;
    if (o.timed_out !== 1'b0) $display("FAIL write_accept: timed out waiting for d_req_ready");
    else pass_cnt++;
    total_cnt++;
    if (o.req !== {1'b1, 32'h0000_1000, 1'b0, 1'b1, 32'h1234_5678, 4'b0011})
      $display("FAIL write_req: got %h expected %h", o.req, {1'b1, 32'h0000_1000, 1'b0, 1'b1, 32'h1234_5678, 4'b0011});
    else pass_cnt++;
    total_cnt++;
    if (o.rv !== 2'b01) $display("FAIL write_ack_route: got {i,d}=%b expected 01", o.rv);
    else pass_cnt++;
    total_cnt++;
    if (o.after !== 2'b00) $display("FAIL write_after: got {busy,pulse_next}=%b expected 00", o.after);
    else pass_cnt++;
  endtask

  task automatic test_data_read_passthru();
    logic [31:0] addrs [2] = '{32'h0040_0000, 32'hC000_0000};
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] rd = $urandom;
      run_txn(1'b1, addrs[i], 1'b0, 32'h0, 4'h0, rd, 0, 0, 1'b0, o);
      total_cnt++;
      if (o.req !== {1'b1, addrs[i], 1'b0, 1'b0, 32'h0, 4'h0})
        $display("FAIL passthru_req[%0d]: got %h expected %h", i, o.req, {1'b1, addrs[i], 1'b0, 1'b0, 32'h0, 4'h0});
      else pass_cnt++;
      total_cnt++;
      if ({o.rv, o.rd} !== {2'b01, rd})
        $display("FAIL passthru_resp[%0d]: got rv=%b data=%h expected rv=01 data=%h", i, o.rv, o.rd, rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    obs_t o;
    logic [31:0] va = 32'hA000_0040;
    logic [31:0] rd = $urandom;
    run_txn(1'b1, va, 1'b0, 32'h0, 4'h0, rd, 5, 1, 1'b1, o);
    total_cnt++;
    if (o.req !== ref_req(1'b1, va, 1'b0, 32'h0, 4'h0))
      $display("FAIL stall_req: got %h expected %h", o.req, ref_req(1'b1, va, 1'b0, 32'h0, 4'h0));
    else pass_cnt++;
    total_cnt++;
    if (o.stall_bad !== 0) $display("FAIL stall_hold: %0d unstable stall cycles, expected 0", o.stall_bad);
    else pass_cnt++;
    total_cnt++;
    if (o.stray_resp !== 0) $display("FAIL stall_stray_resp: %0d early responses, expected 0", o.stray_resp);
    else pass_cnt++;
    total_cnt++;
    if ({o.rv, o.rd} !== {2'b01, rd})
      $display("FAIL stall_resp: got rv=%b data=%h expected rv=01 data=%h", o.rv, o.rd, rd);
    else pass_cnt++;
  endtask

  task automatic test_arbitration();
    logic [3:0] got_seq = '0, exp_seq;
    int ng = 0, ni = 0, nd = 0, both = 0;
    pulse_reset();
`ifdef MEM_VPADDR_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) exp_seq[k] = (k % 2 == 1);  // fetch first, then alternate
`else
    exp_seq = 4'b1111;                                      // data always wins
`endif
    @(negedge clk);
    i_req_valid = 1; i_req_vaddr = 32'h8000_0100;
    d_req_valid = 1; d_req_vaddr = 32'h0000_0200; d_req_wen = 0;
    m_req_ready = 1; m_resp_valid = 1; m_resp_data = $urandom;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (i_req_ready && d_req_ready) both++;
      if (i_req_ready) begin got_seq[ng] = 1'b0; ng++; end
      else if (d_req_ready) begin got_seq[ng] = 1'b1; ng++; end
      if (i_resp_valid) ni++;
      if (d_resp_valid) nd++;
      @(negedge clk);
    end
    i_req_valid = 0; d_req_valid = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (i_resp_valid) ni++;
      if (d_resp_valid) nd++;
      @(negedge clk);
    end
    idle_inputs();
    total_cnt++;
    if (ng !== 4) $display("FAIL arb_grants: got %0d grants expected 4", ng);
    else pass_cnt++;
    total_cnt++;
    if (got_seq !== exp_seq) $display("FAIL arb_order: got %b expected %b (bit k = grant k, 1 = data)", got_seq, exp_seq);
    else pass_cnt++;
    total_cnt++;
    if (both !== 0) $display("FAIL arb_both_ready: %0d cycles with both readies, expected 0", both);
    else pass_cnt++;
    total_cnt++;
    if (nd !== $countones(exp_seq) || ni !== 4 - $countones(exp_seq))
      $display("FAIL arb_resp_route: got i=%0d d=%0d expected i=%0d d=%0d", ni, nd, 4 - $countones(exp_seq), $countones(exp_seq));
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    int stale = 0;
    @(negedge clk);
    d_req_valid = 1; d_req_vaddr = 32'h0000_1234; d_req_wen = 0; m_req_ready = 1;
    #1;
    total_cnt++;
    if (d_req_ready !== 1'b1) $display("FAIL rstwait_accept: got d_req_ready=%b expected 1", d_req_ready);
    else pass_cnt++;
    @(negedge clk);
    d_req_valid = 0;
    @(negedge clk);
    m_req_ready = 0;
    #1;
    total_cnt++;
    if ({busy, m_req_valid} !== 2'b10) $display("FAIL rstwait_in_wait: got {busy,m_req_valid}=%b expected 10", {busy, m_req_valid});
    else pass_cnt++;
    reset = 1;
    #1;
    total_cnt++;
    if ({busy, m_req_valid, m_req_paddr, m_req_wen, m_req_wdata, m_req_wstrb, m_req_uncached,
         i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, i_resp_data, d_resp_data} !== '0)
      $display("FAIL rstwait_outputs: busy=%b m_valid=%b paddr=%h expected all zero", busy, m_req_valid, m_req_paddr);
    else pass_cnt++;
    @(negedge clk);
    reset = 0;
    m_resp_valid = 1; m_resp_data = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (i_resp_valid || d_resp_valid) stale++;
    end
    m_resp_valid = 0;
    total_cnt++;
    if (stale !== 0) $display("FAIL rstwait_stale_resp: %0d stale responses routed, expected 0", stale);
    else pass_cnt++;
    run_txn(1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 32'h0BAD_CAFE, 0, 0, 1'b0, o);
    total_cnt++;
    if (o.req !== {1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 4'h0})
      $display("FAIL rstwait_post_req: got %h expected %h", o.req, {1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 4'h0});
    else pass_cnt++;
    total_cnt++;
    if ({o.rv, o.rd} !== {2'b10, 32'h0BAD_CAFE})
      $display("FAIL rstwait_post_resp: got rv=%b data=%h expected rv=10 data=0badcafe", o.rv, o.rd);
    else pass_cnt++;
  endtask

  task automatic test_random();
    obs_t o;
    for (int it = 0; it < 40; it++) begin
      logic        is_d = 1'($urandom_range(0, 1));
      logic [2:0]  seg  = 3'($urandom_range(0, 7));
      logic [31:0] rnd  = $urandom;
      logic [31:0] va   = {seg, rnd[28:0]};
      logic        wen  = is_d & 1'($urandom_range(0, 1));
      logic [31:0] wd   = $urandom;
      logic [3:0]  ws   = 4'($urandom_range(0, 15));
      logic [31:0] rd   = $urandom;
      int          st   = $urandom_range(0, 2);
      int          lt   = $urandom_range(0, 3);
      run_txn(is_d, va, wen, wd, ws, rd, st, lt, 1'($urandom_range(0, 1)), o);
      total_cnt++;
      if (o.timed_out !== 1'b0) $display("FAIL rand_accept[%0d]: timed out", it);
      else pass_cnt++;
      total_cnt++;
      if (o.req !== ref_req(is_d, va, wen, wd, ws))
        $display("FAIL rand_req[%0d]: va=%h got %h expected %h", it, va, o.req, ref_req(is_d, va, wen, wd, ws));
      else pass_cnt++;
      total_cnt++;
      if (o.rv !== (is_d ? 2'b01 : 2'b10) || (!wen && o.rd !== rd))
        $display("FAIL rand_resp[%0d]: got rv=%b data=%h expected rv=%b data=%h", it, o.rv, o.rd, is_d ? 2'b01 : 2'b10, rd);
      else pass_cnt++;
      total_cnt++;
      if (o.stall_bad !== 0 || o.stray_resp !== 0 || o.after !== 2'b00)
        $display("FAIL rand_hold[%0d]: stall_bad=%0d stray=%0d after=%b expected 0 0 00", it, o.stall_bad, o.stray_resp, o.after);
      else pass_cnt++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_fetch_kseg1();
    test_data_write();
    test_data_read_passthru();
    test_stall();
    test_arbitration();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_vpaddr_arbiter.md
# mem_vpaddr_arbiter

Shares the single downstream memory port between the instruction-fetch and data (LSU) requesters. It translates each accepted virtual address to a physical address and uncached attribute using the fixed MIPS32 segment mapping, then sequences exactly one outstanding transaction at a time. It routes the response back to the owning requester. It sits between the front-end/LSU and the bus interface unit.

## Interface
- DATA_W, 32, width of read/write data on all ports
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req_valid  in  1  fetch request valid (read only)
- i_req_vaddr  in  32  fetch virtual address
- i_req_ready  out  1  fetch request accepted this cycle
- i_resp_valid  out  1  fetch response valid (1-cycle pulse)
- i_resp_data  out  DATA_W  fetch response data
- d_req_valid  in  1  data request valid
- d_req_vaddr  in  32  data virtual address
- d_req_wen  in  1  1 = write, 0 = read
- d_req_wdata  in  DATA_W  write data
- d_req_wstrb  in  DATA_W/8  byte strobes
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  data response valid (1-cycle pulse; also write ack)
- d_resp_data  out  DATA_W  data response data (don't-care for writes)
- m_req_valid, m_req_paddr[31:0], m_req_wen, m_req_wdata, m_req_wstrb, m_req_uncached  out  downstream request
- m_req_ready  in  1  downstream accepts request
- m_resp_valid  in  1  downstream response (read data or write ack)
- m_resp_data  in  DATA_W  downstream read data
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: grant is computed from the valid inputs. The granted requester's ready is asserted combinationally. Its fields are latched, its owner is recorded, and the FSM moves to ISSUE. No valid inputs: stay in IDLE.
  - ISSUE: m_req_valid = 1 with the registered fields. Move to WAIT on m_req_ready.
  - WAIT: on m_resp_valid, register the data and pulse the owner's resp_valid on the next cycle. Move to IDLE.
- Translation (applied at latch):
  - vaddr[31:29] = 3'b100 or 3'b101 (kseg0/kseg1): paddr[31:29] = 0.
  - Otherwise paddr = vaddr.
  - paddr[28:0] = vaddr[28:0] always.
  - m_req_uncached = (vaddr[31:29] == 3'b101).
- Fetch requests always drive m_req_wen = 0, wstrb = 0, wdata = 0.
- Requesters hold valid and fields stable until ready. A valid never withdrawn is required; the arbiter does not check it.
- m_resp_valid outside WAIT is ignored.
- Reset (async, any state): FSM to IDLE, any pending transaction dropped. All outputs 0: m_req_*, ready, resp_valid, resp_data, busy. The arbitration pointer is reset.

## Timing
- Accept in cycle T (ready high in IDLE) -> m_req_valid from T+1. Minimum handshake T+1 with m_req_ready high.
- m_resp_valid in cycle R (WAIT) -> owner resp_valid/resp_data in R+1. FSM in IDLE at R+1, so a new accept is possible in R+1.
- Best-case request-to-response latency: 3 cycles plus downstream latency. Throughput: one transaction per ≥3 cycles.
- i_req_ready and d_req_ready are never high in the same cycle, and never high outside IDLE.

## Configuration
- MEM_VPADDR_ARB_ROUND_ROBIN_EN
  - Defined: round-robin. A 1-bit last-grant pointer is updated on each accept; the other requester wins when both are valid. The reset value favours fetch first.
  - Undefined: fixed priority, data always wins over fetch. No pointer flop.

## Test plan
- Single fetch at 0xBFC00000, m_req_ready=1, response 0xDEADBEEF after 2 cycles -> m_req_paddr=0x1FC00000, uncached=1, wen=0. i_resp_data=0xDEADBEEF one cycle after m_resp_valid; d_resp_valid stays 0.
- Data write to 0x80001000, wdata=0x12345678, wstrb=4'b0011 -> paddr=0x00001000, uncached=0, wen=1, fields unchanged. d_resp_valid pulses on ack.
- Data read at 0x00400000 and 0xC0000000 -> paddr equals vaddr, uncached=0.
- Both valid every cycle for 4 transactions -> with the macro, grants alternate I, D, I, D. Without it, D is granted each time while d_req_valid is held.
- m_req_ready held 0 for 5 cycles -> m_req_valid and fields stable, busy=1, both readies 0. Stray m_resp_valid during ISSUE is ignored.
- Reset asserted in WAIT -> all outputs 0 immediately. The post-reset request is accepted normally and the old response is never routed.
